mipi_csi2_ser: RTL and testbench
================================

// Module: mipi_csi2_ser
// PURPOSE
//  CSI-2 packetizer. Mirror of the CSI-2 receive path: turns an fvi/lvi/dvi pixel stream into a lane byte stream (phy_we/phy_data).
//  - Output bytes: FS/FE short packets, RAW8/RAW10 long packets, ECC header byte, CRC footer bytes.
//  - Feeds the MIPI PHY serializer. One byte per clk while phy_we is high.
// PARAMETERS
//  DATA_WIDTH  10  pixel width; must be >= 10. RAW8 uses dati[7:0]; RAW10 uses dati[9:0].
// PORTS
//  clk          in   1           byte clock; sole clock
//  reset        in   1           asynchronous, active-high reset
//  enable       in   1           start of new packets allowed
//  raw10        in   1           0: RAW8 (DT 0x2A); 1: RAW10 (DT 0x2B); latched at line header
//  vc           in   2           virtual channel, header byte0[7:6]
//  line_pixels  in   16          pixels per line; RAW10 uses line_pixels & ~3
//  gap_cycles   in   8           phy_we-low cycles after each packet; 0 is treated as 1
//  fvi          in   1           frame valid
//  lvi          in   1           line valid
//  dvi          in   1           pixel valid; pixel accepted when dvi && rdy
//  dati         in   DATA_WIDTH  pixel data
//  rdy          out  1           pixel accept
//  phy_we       out  1           byte valid; continuous for the whole of each packet
//  phy_data     out  8           lane byte
//  underrun     out  1           sticky; set by padding, cleared by reset or FS emission
//  busy         out  1           state != ST_IDLE
// BEHAVIOUR
//  Reset: all outputs 0 (rdy, phy_we, phy_data, underrun, busy); state=ST_IDLE; pending flags cleared.
//    Mid-packet reset drops phy_we in the same cycle (async).
//  Edge detection: fvi and lvi are registered.
//    - Rise of fvi sets fs_pend; fall of fvi sets fe_pend.
//    - Rise of lvi sets ls_pend.
//    - Flags persist until serviced. Service priority: FS > LS > FE.
//    - fvi and lvi rising in the same cycle gives FS then line packet.
//  States:
//    ST_IDLE: wait for a pending flag with enable=1. With enable=0 flags are held, not serviced.
//    ST_HDR: 4 bytes {vc,DT}, WC[7:0], WC[15:8], ECC.
//      - Short packets: FS DT=0x00, FE DT=0x01, WC field=0x0000.
//      - ECC = CSI-2 6-bit Hamming over the 24 header bits; ECC[7:6]=0.
//      - Short packet goes to ST_GAP. Long packet goes to ST_DATA8 or ST_DATA10.
//    ST_DATA8: WC=line_pixels. rdy=1. Each accepted pixel gives phy_data=dati[7:0] next cycle.
//    ST_DATA10: WC=lp+lp/4, lp=line_pixels&~3.
//      - Pixels p0..p3 emit p[9:2] on acceptance.
//      - Then one cycle with rdy=0 emits {p3[1:0],p2[1:0],p1[1:0],p0[1:0]}.
//      - Repeats until WC bytes are sent.
//    ST_CRC: 2 bytes, CRC[7:0] then CRC[15:8].
//    ST_GAP: phy_we=0 for gap_cycles. Then ST_IDLE.
//  Latency: accepted pixel appears on phy_data exactly 1 cycle later. rdy=0 in all non-data states.
//  Underrun: dvi=0 in a data state while bytes remain.
//    - Emit 0x00 filler that cycle (phy_we stays 1); byte count still advances.
//    - RAW10 filler pixels contribute 00 LSBs.
//    - underrun<=1.
//  lvi falling before the line completes: the remainder is padded as underrun.
//    Extra pixels after WC are not accepted (rdy=0).
//  WC reaching 0 always completes the packet. The next packet never starts before the gap ends.
//  line_pixels=0 (or <4 in RAW10): header with WC=0, then CRC=0xFFFF (seed), no data.
//  enable falling mid-packet: current packet completes normally.
// CONFIGURATION
//  CSI2_TX_CRC_EN defined:
//    - CRC-16, poly x^16+x^12+x^5+1, reflected (0x8408), seed 0xFFFF.
//    - Computed over payload bytes only, including filler.
//  CSI2_TX_CRC_EN undefined: footer bytes are 0x00,0x00. The CRC logic is absent.
//  Footer length (2 bytes) and timing are identical in both builds.
// TESTING
//  1. reset, fvi rise, enable=1, gap_cycles=3
//     -> bytes 00 00 00 00 with phy_we=1 for 4 cycles; then phy_we=0 for 3 cycles.
//  2. fvi fall -> bytes 01 00 00 07; underrun stays 0.
//  3. RAW8, vc=1, line_pixels=4, pixels 11 22 33 44 presented continuously
//     -> 6A 04 00 ECC, then 11 22 33 44, then CRC lo/hi (model-checked). rdy high only 4 cycles.
//  4. RAW10, line_pixels=4, pixels 3FF 000 155 2AA
//     -> header WC=0x0005; payload FF 00 55 AA 93; rdy low on the LSB cycle.
//  5. RAW8, line_pixels=8, dvi dropped after 3 pixels
//     -> 5 filler 00 bytes; phy_we continuous; underrun=1; next FS clears underrun.
//  6. fvi and lvi rise together, then reset asserted mid-payload
//     -> FS precedes line header; phy_we=0 immediately; after release no packet until a new edge.

Source files
------------

// File: rtl/mipi_csi2_ser.sv
// CSI-2 packetizer: fvi/lvi/dvi pixel stream to FS/FE short packets and RAW8/RAW10 long packets on a byte lane.
// Define CSI2_TX_CRC_EN to compute the CRC-16 payload footer; otherwise the footer bytes are 0x00,0x00.
module mipi_csi2_ser #(
   parameter int DATA_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  raw10,
   input  logic [1:0]            vc,
   input  logic [15:0]           line_pixels,
   input  logic [7:0]            gap_cycles,
   input  logic                  fvi,
   input  logic                  lvi,
   input  logic                  dvi,
   input  logic [DATA_WIDTH-1:0] dati,
   output logic                  rdy,
   output logic                  phy_we,
   output logic [7:0]            phy_data,
   output logic                  underrun,
   output logic                  busy
);
   typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA8, ST_DATA10, ST_CRC, ST_GAP} state_t;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_RAW8  = 6'h2A;
   localparam logic [5:0] DT_RAW10 = 6'h2B;

   // d[7:0] = data identifier, d[23:8] = word count
   function automatic logic [7:0] ecc_calc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return {2'b00, p};
   endfunction

`ifdef CSI2_TX_CRC_EN
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
      return c;
   endfunction
`endif

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] rem_q, rem_d;
   logic [2:0]  grp_q, grp_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic        fvi_q, lvi_q, arm_q;
   logic        fs_pend_q, fs_pend_d;
   logic        fe_pend_q, fe_pend_d;
   logic        ls_pend_q, ls_pend_d;
   logic        line_on_q, line_on_d;
   logic        underrun_q, underrun_d;
   logic        phy_we_q, phy_we_d;
   logic [7:0]  phy_data_q, phy_data_d;
   logic        long_q, long_d;
   logic        raw10_q, raw10_d;
   logic [7:0]  di_q, di_d;
   logic [15:0] wc_q, wc_d;
   logic [7:0]  lsb_q, lsb_d;
`ifdef CSI2_TX_CRC_EN
   logic [15:0] crc_q, crc_d;
`endif

   logic        fvi_rise, fvi_fall, lvi_rise, any_pend, start, pix_slot, take;
   logic [7:0]  gap_eff;
   logic [15:0] lp10, wc10;

   // Edges are ignored for the first cycle after reset so levels held through reset are not seen as edges
   assign fvi_rise = arm_q & fvi & ~fvi_q;
   assign fvi_fall = arm_q & ~fvi & fvi_q;
   assign lvi_rise = arm_q & lvi & ~lvi_q;
   assign any_pend = fs_pend_q | fe_pend_q | ls_pend_q;
   assign gap_eff  = (gap_cycles == 8'd0) ? 8'd1 : gap_cycles;
   assign lp10     = line_pixels & 16'hFFFC;
   assign wc10     = lp10 + {2'b00, lp10[15:2]};

   assign pix_slot = (state_q == ST_DATA8) || ((state_q == ST_DATA10) && (grp_q != 3'd4));
   assign rdy      = pix_slot && line_on_q && lvi;
   assign take     = rdy && dvi;

   assign phy_we   = phy_we_q;
   assign phy_data = phy_data_q;
   assign underrun = underrun_q;
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      grp_d      = grp_q;
      gap_cnt_d  = gap_cnt_q;
      fs_pend_d  = fs_pend_q | fvi_rise;
      fe_pend_d  = fe_pend_q | fvi_fall;
      ls_pend_d  = ls_pend_q | lvi_rise;
      line_on_d  = line_on_q & lvi;
      underrun_d = underrun_q;
      phy_we_d   = 1'b0;
      phy_data_d = 8'h00;
      long_d     = long_q;
      raw10_d    = raw10_q;
      di_d       = di_q;
      wc_d       = wc_q;
      lsb_d      = lsb_q;
`ifdef CSI2_TX_CRC_EN
      crc_d      = crc_q;
`endif
      start      = 1'b0;

      case (state_q)
         ST_IDLE: start = enable && any_pend;
         ST_HDR: begin
            phy_we_d = 1'b1;
            case (idx_q)
               2'd0:    phy_data_d = di_q;
               2'd1:    phy_data_d = wc_q[7:0];
               2'd2:    phy_data_d = wc_q[15:8];
               default: phy_data_d = ecc_calc({wc_q, di_q});
            endcase
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               idx_d = 2'd0;
               rem_d = wc_q;
               grp_d = 3'd0;
               if (!long_q) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = 8'd1;
               end else if (wc_q == 16'd0) begin
                  state_d = ST_CRC;
               end else begin
                  state_d = raw10_q ? ST_DATA10 : ST_DATA8;
               end
            end
         end
         ST_DATA8, ST_DATA10: begin
            phy_we_d = 1'b1;
            if (state_q == ST_DATA10 && grp_q == 3'd4) begin
               phy_data_d = lsb_q;
               grp_d      = 3'd0;
            end else begin
               if (state_q == ST_DATA10) begin
                  phy_data_d = take ? dati[9:2] : 8'h00;
                  lsb_d[{grp_q[1:0], 1'b0} +: 2] = take ? dati[1:0] : 2'b00;
                  grp_d = grp_q + 3'd1;
               end else begin
                  phy_data_d = take ? dati[7:0] : 8'h00;
               end
               if (!take) underrun_d = 1'b1;
            end
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = ST_CRC;
`ifdef CSI2_TX_CRC_EN
            crc_d = crc_step(crc_q, phy_data_d);
`endif
         end
         ST_CRC: begin
            phy_we_d = 1'b1;
`ifdef CSI2_TX_CRC_EN
            phy_data_d = (idx_q == 2'd0) ? crc_q[7:0] : crc_q[15:8];
`endif
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd1) begin
               idx_d     = 2'd0;
               state_d   = ST_GAP;
               gap_cnt_d = 8'd1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q >= gap_eff) begin
               start   = enable && any_pend;
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Service priority FS > LS > FE; a new edge in the same cycle re-arms its flag
      if (start) begin
         state_d = ST_HDR;
         idx_d   = 2'd0;
         long_d  = 1'b0;
         wc_d    = 16'd0;
         if (fs_pend_q) begin
            di_d       = {vc, DT_FS};
            fs_pend_d  = fvi_rise;
            underrun_d = 1'b0;
         end else if (ls_pend_q) begin
            long_d    = 1'b1;
            raw10_d   = raw10;
            di_d      = {vc, raw10 ? DT_RAW10 : DT_RAW8};
            wc_d      = raw10 ? wc10 : line_pixels;
            ls_pend_d = lvi_rise;
            line_on_d = 1'b1;
`ifdef CSI2_TX_CRC_EN
            crc_d     = 16'hFFFF;
`endif
         end else begin
            di_d      = {vc, DT_FE};
            fe_pend_d = fvi_fall;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
         rem_q      <= 16'd0;
         grp_q      <= 3'd0;
         gap_cnt_q  <= 8'd0;
         fvi_q      <= 1'b0;
         lvi_q      <= 1'b0;
         arm_q      <= 1'b0;
         fs_pend_q  <= 1'b0;
         fe_pend_q  <= 1'b0;
         ls_pend_q  <= 1'b0;
         line_on_q  <= 1'b0;
         underrun_q <= 1'b0;
         phy_we_q   <= 1'b0;
         phy_data_q <= 8'h00;
         long_q     <= 1'b0;
         raw10_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         grp_q      <= grp_d;
         gap_cnt_q  <= gap_cnt_d;
         fvi_q      <= fvi;
         lvi_q      <= lvi;
         arm_q      <= 1'b1;
         fs_pend_q  <= fs_pend_d;
         fe_pend_q  <= fe_pend_d;
         ls_pend_q  <= ls_pend_d;
         line_on_q  <= line_on_d;
         underrun_q <= underrun_d;
         phy_we_q   <= phy_we_d;
         phy_data_q <= phy_data_d;
         long_q     <= long_d;
         raw10_q    <= raw10_d;
      end
   end

   always_ff @(posedge clk) begin
      di_q  <= di_d;
      wc_q  <= wc_d;
      lsb_q <= lsb_d;
`ifdef CSI2_TX_CRC_EN
      crc_q <= crc_d;
`endif
   end

endmodule

// File: tb/tb_mipi_csi2_ser.sv
// Directed bench for mipi_csi2_ser; footer expectations follow CSI2_TX_CRC_EN.
module tb_mipi_csi2_ser;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        raw10 = 1'b0;
   logic [1:0]  vc = 2'd0;
   logic [15:0] line_pixels = 16'd0;
   logic [7:0]  gap_cycles = 8'd3;
   logic        fvi = 1'b0;
   logic        lvi = 1'b0;
   logic        dvi = 1'b0;
   logic [9:0]  dati = 10'd0;
   logic        rdy, phy_we, underrun, busy;
   logic [7:0]  phy_data;

   int tests = 0;
   int fails = 0;

   mipi_csi2_ser #(.DATA_WIDTH(10)) dut (
      .clk(clk), .reset(reset), .enable(enable), .raw10(raw10), .vc(vc),
      .line_pixels(line_pixels), .gap_cycles(gap_cycles), .fvi(fvi), .lvi(lvi),
      .dvi(dvi), .dati(dati), .rdy(rdy), .phy_we(phy_we), .phy_data(phy_data),
      .underrun(underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // Per-cycle log of {busy, phy_we, phy_data}
   bit         rec = 1'b0;
   logic [9:0] log_q[$];
   always @(negedge clk) if (rec) log_q.push_back({busy, phy_we, phy_data});

   logic [7:0] bq[$];
   logic [7:0] exp_b[$];
   logic [9:0] pix[8];
   int nburst, gap1, blen1, first_we;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic analyze();
      int  run0;
      bit  prev;
      bq.delete();
      nburst = 0; gap1 = -1; blen1 = 0; first_we = -1; run0 = 0; prev = 1'b0;
      foreach (log_q[i]) begin
         if (log_q[i][8]) begin
            bq.push_back(log_q[i][7:0]);
            if (!prev) begin
               nburst++;
               if (nburst == 1) first_we = i;
               if (nburst == 2) gap1 = run0;
            end
            if (nburst == 1) blen1++;
            run0 = 0;
         end else begin
            run0++;
         end
         prev = log_q[i][8];
      end
   endtask

   function automatic logic [15:0] ref_footer(input logic [7:0] b[$]);
`ifdef CSI2_TX_CRC_EN
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (b[i]) begin
         c = c ^ {8'h00, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
      return c;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic drive_line(input int npix, input int ncyc, output int nacc, output int nrdy);
      int idx;
      bit acc;
      idx = 0; nacc = 0; nrdy = 0;
      lvi = 1'b1;
      @(negedge clk);
      for (int c = 0; c < ncyc; c++) begin
         dvi  = (idx < npix);
         dati = (idx < npix) ? pix[idx] : 10'd0;
         acc  = rdy && dvi;
         if (rdy) nrdy++;
         @(negedge clk);
         if (acc) begin idx++; nacc++; end
      end
      dvi = 1'b0;
      lvi = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc(3);
      tests++; if (phy_we !== 1'b0) begin fails++; $display("FAIL reset_phy_we got %b exp 0", phy_we); end
      tests++; if (phy_data !== 8'h00) begin fails++; $display("FAIL reset_phy_data got %h exp 00", phy_data); end
      tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy got %b exp 0", rdy); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", underrun); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      reset = 1'b0;
   endtask

   task automatic test_fs();
      enable = 1'b1; gap_cycles = 8'd3;
      cyc(3);
      log_q.delete(); rec = 1'b1;
      fvi = 1'b1;
      cyc(20);
      analyze();
      tests++; if (nburst != 1 || blen1 != 4) begin fails++; $display("FAIL fs_shape got bursts=%0d len=%0d exp 1/4", nburst, blen1); end
      exp_b = '{8'h00, 8'h00, 8'h00, 8'h00};
      tests++; if (bq.size() != exp_b.size()) begin fails++; $display("FAIL fs_len got %0d exp %0d", bq.size(), exp_b.size()); end
      else foreach (exp_b[i]) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL fs_byte%0d got %h exp %h", i, bq[i], exp_b[i]); end
      end
      if (first_we >= 0) begin
         tests++; if (log_q[first_we][9] !== 1'b1) begin fails++; $display("FAIL fs_busy got %b exp 1", log_q[first_we][9]); end
         tests++; if (log_q[first_we+4][8] !== 1'b0 || log_q[first_we+5][8] !== 1'b0 || log_q[first_we+6][8] !== 1'b0) begin
            fails++; $display("FAIL fs_gap_low got %b%b%b exp 000", log_q[first_we+4][8], log_q[first_we+5][8], log_q[first_we+6][8]);
         end
      end
   endtask

   task automatic test_fe_enable();
      enable = 1'b0;
      log_q.delete();
      fvi = 1'b0;
      cyc(10);
      analyze();
      tests++; if (nburst != 0) begin fails++; $display("FAIL fe_disabled got bursts=%0d exp 0", nburst); end
      enable = 1'b1;
      cyc(15);
      analyze();
      exp_b = '{8'h01, 8'h00, 8'h00, 8'h07};
      tests++; if (bq.size() != exp_b.size()) begin fails++; $display("FAIL fe_len got %0d exp %0d", bq.size(), exp_b.size()); end
      else foreach (exp_b[i]) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL fe_byte%0d got %h exp %h", i, bq[i], exp_b[i]); end
      end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL fe_underrun got %b exp 0", underrun); end
   endtask

   task automatic test_raw8();
      int nacc, nrdy;
      logic [7:0] pay[$];
      logic [15:0] crc;
      fvi = 1'b1;
      cyc(20);
      raw10 = 1'b0; vc = 2'd1; line_pixels = 16'd4;
      pix[0] = 10'h011; pix[1] = 10'h022; pix[2] = 10'h033; pix[3] = 10'h044;
      pix[4] = 10'h055; pix[5] = 10'h066;
      log_q.delete();
      drive_line(6, 30, nacc, nrdy);
      cyc(10);
      analyze();
      pay = '{8'h11, 8'h22, 8'h33, 8'h44};
      crc = ref_footer(pay);
      exp_b = '{8'h6A, 8'h04, 8'h00, 8'h25, 8'h11, 8'h22, 8'h33, 8'h44};
      exp_b.push_back(crc[7:0]); exp_b.push_back(crc[15:8]);
      tests++; if (bq.size() != exp_b.size()) begin fails++; $display("FAIL raw8_len got %0d exp %0d", bq.size(), exp_b.size()); end
      else foreach (exp_b[i]) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL raw8_byte%0d got %h exp %h", i, bq[i], exp_b[i]); end
      end
      tests++; if (nrdy != 4 || nacc != 4) begin fails++; $display("FAIL raw8_rdy got rdy=%0d acc=%0d exp 4/4", nrdy, nacc); end
      tests++; if (nburst != 1) begin fails++; $display("FAIL raw8_cont got bursts=%0d exp 1", nburst); end
   endtask

   task automatic test_raw10();
      int nacc, nrdy;
      logic [7:0] pay[$];
      logic [15:0] crc;
      raw10 = 1'b1; vc = 2'd0; line_pixels = 16'd4;
      pix[0] = 10'h3FF; pix[1] = 10'h000; pix[2] = 10'h155; pix[3] = 10'h2AA;
      log_q.delete();
      drive_line(4, 30, nacc, nrdy);
      cyc(10);
      analyze();
      pay = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'h93};
      crc = ref_footer(pay);
      exp_b = '{8'h2B, 8'h05, 8'h00, 8'h2E, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h93};
      exp_b.push_back(crc[7:0]); exp_b.push_back(crc[15:8]);
      tests++; if (bq.size() != exp_b.size()) begin fails++; $display("FAIL raw10_len got %0d exp %0d", bq.size(), exp_b.size()); end
      else foreach (exp_b[i]) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL raw10_byte%0d got %h exp %h", i, bq[i], exp_b[i]); end
      end
      tests++; if (nrdy != 4) begin fails++; $display("FAIL raw10_rdy got %0d exp 4", nrdy); end
      tests++; if (nburst != 1) begin fails++; $display("FAIL raw10_cont got bursts=%0d exp 1", nburst); end
   endtask

   task automatic test_zero_wc();
      int nacc, nrdy;
      logic [7:0] pay[$];
      logic [15:0] crc;
      raw10 = 1'b1; vc = 2'd0; line_pixels = 16'd3;
      pix[0] = 10'h123; pix[1] = 10'h321;
      log_q.delete();
      drive_line(2, 20, nacc, nrdy);
      cyc(10);
      analyze();
      pay.delete();
      crc = ref_footer(pay);
      exp_b = '{8'h2B, 8'h00, 8'h00, 8'h17};
      exp_b.push_back(crc[7:0]); exp_b.push_back(crc[15:8]);
      tests++; if (bq.size() != exp_b.size()) begin fails++; $display("FAIL zwc_len got %0d exp %0d", bq.size(), exp_b.size()); end
      else foreach (exp_b[i]) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL zwc_byte%0d got %h exp %h", i, bq[i], exp_b[i]); end
      end
      tests++; if (nrdy != 0) begin fails++; $display("FAIL zwc_rdy got %0d exp 0", nrdy); end
   endtask

   task automatic test_underrun();
      int nacc, nrdy;
      logic [7:0] pay[$];
      logic [15:0] crc;
      raw10 = 1'b0; vc = 2'd0; line_pixels = 16'd8;
      pix[0] = 10'h0AA; pix[1] = 10'h0BB; pix[2] = 10'h0CC;
      log_q.delete();
      drive_line(3, 30, nacc, nrdy);
      cyc(10);
      analyze();
      pay = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      crc = ref_footer(pay);
      exp_b = '{8'h2A, 8'h08, 8'h00, 8'h35, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_b.push_back(crc[7:0]); exp_b.push_back(crc[15:8]);
      tests++; if (bq.size() != exp_b.size()) begin fails++; $display("FAIL ur_len got %0d exp %0d", bq.size(), exp_b.size()); end
      else foreach (exp_b[i]) begin
         tests++; if (bq[i] !== exp_b[i]) begin fails++; $display("FAIL ur_byte%0d got %h exp %h", i, bq[i], exp_b[i]); end
      end
      tests++; if (nburst != 1) begin fails++; $display("FAIL ur_cont got bursts=%0d exp 1", nburst); end
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_flag got %b exp 1", underrun); end
      fvi = 1'b0;
      cyc(20);
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL ur_after_fe got %b exp 1", underrun); end
      fvi = 1'b1;
      cyc(20);
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL ur_fs_clear got %b exp 0", underrun); end
   endtask

   task automatic test_back_to_back_reset();
      int k;
      raw10 = 1'b0; vc = 2'd0; line_pixels = 16'd8;
      fvi = 1'b0;
      cyc(20);
      log_q.delete();
      fvi = 1'b1; lvi = 1'b1; dvi = 1'b1; dati = 10'h05A;
      k = 0;
      while (!rdy && k < 80) begin @(negedge clk); k++; end
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL b2b_rdy_timeout got %b exp 1", rdy); end
      cyc(2);
      #2 reset = 1'b1;
      #1;
      tests++; if (phy_we !== 1'b0) begin fails++; $display("FAIL b2b_reset_we got %b exp 0", phy_we); end
      tests++; if (busy !== 1'b0 || rdy !== 1'b0) begin fails++; $display("FAIL b2b_reset_ctl got busy=%b rdy=%b exp 0/0", busy, rdy); end
      analyze();
      tests++; if (bq.size() < 5) begin fails++; $display("FAIL b2b_len got %0d exp >=5", bq.size()); end
      else begin
         tests++; if (bq[0] !== 8'h00 || bq[3] !== 8'h00) begin fails++; $display("FAIL b2b_fs got %h/%h exp 00/00", bq[0], bq[3]); end
         tests++; if (bq[4] !== 8'h2A) begin fails++; $display("FAIL b2b_lhdr got %h exp 2a", bq[4]); end
      end
      tests++; if (gap1 != 3) begin fails++; $display("FAIL b2b_gap got %0d exp 3", gap1); end
      @(negedge clk);
      reset = 1'b0;
      log_q.delete();
      cyc(30);
      analyze();
      tests++; if (nburst != 0) begin fails++; $display("FAIL b2b_no_packet got bursts=%0d exp 0", nburst); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got %b exp 0", busy); end
      rec = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fs();
      test_fe_enable();
      test_raw8();
      test_raw10();
      test_zero_wc();
      test_underrun();
      test_back_to_back_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
endmodule
